// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family.
package counter_pkg;

    // Default counter width used when no override is given.
    localparam int DEFAULT_CNT_WIDTH = 8;

    // Direction encodings for the mode input.
    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage : counter_pkg

// File: rtl/up_down_counter.sv
// Loadable modulo-2^WIDTH up/down counter with asynchronous active-low clear.
// The port order is relied on by positional instantiations and must not change.
module up_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
    output logic [WIDTH-1:0] count,
    input  logic             clr,
    input  logic             ld,
    input  logic             clk,
    input  logic             mode,
    input  logic [WIDTH-1:0] din
);

    // Step of one, sized to the counter so arithmetic truncates naturally.
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    // Next-state selection: load wins over counting; counting wraps modulo 2^WIDTH.
    always_comb begin
        count_next_s = count_r;
        if (ld) begin
            count_next_s = din;
        end else begin
            case (mode)
                MODE_UP:   count_next_s = count_r + ONE;
                MODE_DOWN: count_next_s = count_r - ONE;
                default:   count_next_s = count_r;
            endcase
        end
    end

    // Count register; clr clears it immediately, independent of clk.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_r <= '0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a modular-arithmetic reference model for an 8-bit and a 4-bit counter.
module tb_up_down_counter;

    logic       clk;
    logic       clr;
    logic       ld;
    logic       mode;
    logic [7:0] din8;
    logic [3:0] din4;
    logic [7:0] count8;
    logic [3:0] count4;

    int errors;
    int checks;
    int m8;
    int m4;

    up_down_counter #(.WIDTH(8)) dut8 (
        .count (count8),
        .clr   (clr),
        .ld    (ld),
        .clk   (clk),
        .mode  (mode),
        .din   (din8)
    );

    up_down_counter #(.WIDTH(4)) dut4 (
        .count (count4),
        .clr   (clr),
        .ld    (ld),
        .clk   (clk),
        .mode  (mode),
        .din   (din4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference rule for one clock edge of a counter of the given modulus.
    function automatic int ref_next(input int cur, input int modulus, input logic l,
                                    input logic m, input int d);
        if (!clr)      return 0;
        else if (l)    return d % modulus;
        else if (m)    return (cur - 1 + modulus) % modulus;
        else           return (cur + 1) % modulus;
    endfunction

    // Advance one edge and compare both counters against the model.
    task automatic tick(input string tag);
        int e8;
        int e4;
        e8 = ref_next(m8, 256, ld, mode, int'(din8));
        e4 = ref_next(m4, 16, ld, mode, int'(din4));
        @(posedge clk);
        #1;
        m8 = e8;
        m4 = e4;
        check({tag, "_w8"}, 32'(count8), 32'(m8));
        check({tag, "_w4"}, 32'(count4), 32'(m4));
    endtask

    task automatic drive(input logic l, input logic m, input logic [7:0] d8, input logic [3:0] d4);
        ld   = l;
        mode = m;
        din8 = d8;
        din4 = d4;
    endtask

    // Assert clr between edges and confirm the clear lands before the next edge.
    task automatic async_clear(input string tag);
        #2;
        clr = 1'b0;
        #1;
        m8 = 0;
        m4 = 0;
        check({tag, "_w8"}, 32'(count8), 32'd0);
        check({tag, "_w4"}, 32'(count4), 32'd0);
        #1;
        clr = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m8 = 0;
        m4 = 0;
        clr = 1'b0;
        drive(1'b1, 1'b0, 8'd100, 4'd10);

        // Reset dominates load while clr is low.
        repeat (3) tick("rst_hold");

        // Release clr between edges, then load.
        #2;
        clr = 1'b1;
        tick("load100");
        check("load100_abs", 32'(count8), 32'd100);
        drive(1'b0, 1'b0, 8'd0, 4'd0);
        tick("up101");
        tick("up102");
        tick("up103");
        check("up103_abs", 32'(count8), 32'd103);

        // Down counting and direction change with no dead cycle.
        drive(1'b1, 1'b0, 8'd100, 4'd4);
        tick("reload100");
        drive(1'b0, 1'b1, 8'd0, 4'd0);
        tick("dn99");
        tick("dn98");
        tick("dn97");
        check("dn97_abs", 32'(count8), 32'd97);
        drive(1'b0, 1'b0, 8'd0, 4'd0);
        tick("up98");
        check("up98_abs", 32'(count8), 32'd98);

        // Load has priority over a down step.
        drive(1'b1, 1'b0, 8'd50, 4'd7);
        tick("load50");
        drive(1'b1, 1'b1, 8'd5, 4'd5);
        tick("ldprio");
        check("ldprio_abs", 32'(count8), 32'd5);

        // Wrap upward then downward.
        drive(1'b1, 1'b0, 8'd254, 4'd14);
        tick("load254");
        drive(1'b0, 1'b0, 8'd0, 4'd0);
        tick("wrap_up255");
        tick("wrap_up0");
        check("wrap_up0_abs", 32'(count8), 32'd0);
        tick("wrap_up1");
        drive(1'b1, 1'b1, 8'd1, 4'd1);
        tick("load1");
        drive(1'b0, 1'b1, 8'd0, 4'd0);
        tick("wrap_dn0");
        tick("wrap_dn255");
        check("wrap_dn255_abs", 32'(count8), 32'd255);
        tick("wrap_dn254");

        // Narrow instance: 15 wraps to 0 and back.
        drive(1'b1, 1'b0, 8'd15, 4'd15);
        tick("w4_load15");
        drive(1'b0, 1'b0, 8'd0, 4'd0);
        tick("w4_up");
        check("w4_up_abs", 32'(count4), 32'd0);
        drive(1'b0, 1'b1, 8'd0, 4'd0);
        tick("w4_dn");
        check("w4_dn_abs", 32'(count4), 32'd15);

        // Mid-count asynchronous clear, then resume from 0.
        drive(1'b1, 1'b0, 8'd37, 4'd9);
        tick("load37");
        drive(1'b0, 1'b0, 8'd0, 4'd0);
        async_clear("async_clr");
        tick("resume_up");
        check("resume_up_abs", 32'(count8), 32'd1);

        // Randomized traffic with occasional asynchronous clears.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  8'($urandom), 4'($urandom));
            if ($urandom_range(0, 49) == 0) begin
                async_clear("rnd_clr");
            end
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_up_down_counter

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
Synchronous, loadable, modulo-2^WIDTH binary up/down counter. Provides a general-purpose count register for control and timing blocks; software or upstream logic may preload it and select the count direction every cycle. Single clock domain with an asynchronous active-low clear.

Parameters:
WIDTH, 8, bit width of din and count; legal values are 2..32.

Ports:
clk    input   1      rising-edge clock
clr    input   1      reset; asynchronous, active-low (0 = clear)
count  output  WIDTH  current counter value, driven directly from the register
ld     input   1      synchronous load enable, active-high
mode   input   1      direction select: 0 = count up, 1 = count down
din    input   WIDTH  parallel load value, sampled when ld=1

- Positional port order is fixed as: count, clr, ld, clk, mode, din. Existing instantiations connect by position, so this order must not change.
- One clock; reset is asynchronous and active-low (clk, clr).

Behaviour:
- Reset: while clr=0, count is 0 immediately, independent of clk. Reset has priority over every other input.
- Deassertion of clr is asynchronous. The first clocked update happens at the first rising clk edge with clr=1.
- Priority at each rising clk edge when clr=1: ld first, then counting.
  - ld=1: count <= din. mode is ignored on that edge.
  - ld=0, mode=0: count <= count + 1.
  - ld=0, mode=1: count <= count - 1.
- Counting runs on every edge; there is no separate enable. Holding the value requires reloading it with ld=1.
- Latency: a load or count step is visible on count one edge after the inputs are sampled. There is no combinational path from inputs to count.
- Wrap-around is modulo 2^WIDTH, with no saturation and no flags.
  - Up from 2^WIDTH-1 gives 0 (8-bit: 255 to 0).
  - Down from 0 gives 2^WIDTH-1 (8-bit: 0 to 255).
- Changing mode takes effect at the next edge with no dead cycle.
- Reset asserted mid-count: count goes to 0 asynchronously. After release, counting resumes from 0 in the current mode.
- Unknown or X inputs are not sanitised. The verification bench must drive ld, mode and din to known values whenever clr=1.
- Arithmetic is unsigned, truncated to WIDTH bits.

Decomposition:
- Shared package (counter_pkg):
  - constant DEFAULT_CNT_WIDTH = 8
  - constants MODE_UP = 1'b0 and MODE_DOWN = 1'b1
- No sub-module. Next-state selection (load, increment, decrement) is a single always block that drives one register.

Test Plan:
- Reset: hold clr=0 with ld=1, din=100 and toggle clk. Required: count stays 0. Then drive clr=0 between clock edges with count=37. Required: count is 0 before the next edge.
- Load: release clr with ld=1, din=100, mode=0 for one edge. Required: count=100. Then ld=0 for 3 edges. Required: count goes 101, 102, 103.
- Down count: load 100, then mode=1, ld=0 for 3 edges. Required: count goes 99, 98, 97. Then switch to mode=0 for 1 edge. Required: count=98.
- Load priority: ld=1, din=5, mode=1 at count=50. Required: count=5, not 49.
- Wrap: load 254 with mode=0 and count 3 edges. Required: 255, 0, 1. Then load 1 with mode=1 and count 3 edges. Required: 0, 255, 254.
- Parameter: WIDTH=4, load 15, up 1 edge. Required: count=0. Then down 1 edge. Required: count=15.
